// File: rtl/mem_io_arbiter.sv
// Purpose : two-requester arbiter/sequencer sharing one data-memory port and the 16-bit IO bus.
// Latency : ack in cycle 2 after the sampling edge (cycle 2+MEM_LAT for memory reads); IDLE >= 1 cycle between accesses.
// Backpr. : a requester holds req and its qualifiers until its ack; the loser of a tie waits in IDLE.
//
// Ports:
//   clock, reset           - rising-edge clock, asynchronous active-low reset
//   rN_req/we/addr/wdata   - requester N access request and qualifiers (N = 0 CPU, 1 loader/debug)
//   rN_ack/rdata           - one-cycle completion pulse, read data held until that requester's next read ack
//   err                    - pulses with ack for an unmapped IO address
//   m_*                    - data-memory port (m_rdata valid MEM_LAT cycles after m_en)
//   io_*, led_cs, sw_cs    - IO bus strobes, chip selects and data
//   owner, busy            - current grant and "not IDLE" status
module mem_io_arbiter #(
  parameter int          MEM_LAT  = 1,
  parameter logic [31:0] IO_BASE  = 32'hFFFFFC00,
  parameter logic [31:0] LED_ADDR = 32'hFFFFFC60,
  parameter logic [31:0] SW_ADDR  = 32'hFFFFFC70
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        r0_req,
  input  logic        r0_we,
  input  logic [31:0] r0_addr,
  input  logic [31:0] r0_wdata,
  input  logic        r1_req,
  input  logic        r1_we,
  input  logic [31:0] r1_addr,
  input  logic [31:0] r1_wdata,
  output logic        r0_ack,
  output logic [31:0] r0_rdata,
  output logic        r1_ack,
  output logic [31:0] r1_rdata,
  output logic        err,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        io_rd,
  output logic        io_wr,
  output logic        led_cs,
  output logic        sw_cs,
  output logic [15:0] io_wdata,
  input  logic [15:0] io_rdata,
  output logic        owner,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

  state_t      state, state_nxt;
  logic        last;      // requester granted most recently; the other one wins a tie
  logic        sel;       // winner of the current arbitration
  logic        we_q;      // latched direction of the access in flight
  logic        io_q;      // access in flight targets IO space
  logic        unm_q;     // IO access in flight hit no register
  logic [2:0]  cnt;       // remaining WAIT cycles minus one

  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_io;
  logic        sel_led;
  logic        sel_sw;

  // Winner's qualifiers and address decode, used at the grant edge so that
  // the strobes come straight out of flops during ISSUE.
  assign sel_we    = sel ? r1_we    : r0_we;
  assign sel_addr  = sel ? r1_addr  : r0_addr;
  assign sel_wdata = sel ? r1_wdata : r0_wdata;
  assign sel_io    = (sel_addr[31:10] == IO_BASE[31:10]);
  assign sel_led   = sel_io && (sel_addr[31:2] == LED_ADDR[31:2]);
  assign sel_sw    = sel_io && (sel_addr[31:2] == SW_ADDR[31:2]);

  assign busy = (state != IDLE);

  always_comb begin
    sel       = 1'b0;
    state_nxt = state;
    if (r0_req && r1_req) begin
      sel = ~last;
    end else if (r1_req) begin
      sel = 1'b1;
    end
    case (state)
      IDLE:    if (r0_req || r1_req) state_nxt = ISSUE;
      ISSUE:   state_nxt = (!io_q && !we_q) ? WAIT : ACK;
      WAIT:    if (cnt == 3'd0) state_nxt = ACK;
      ACK:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      last     <= 1'b1;
      owner    <= 1'b0;
      we_q     <= 1'b0;
      io_q     <= 1'b0;
      unm_q    <= 1'b0;
      cnt      <= 3'd0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= 32'd0;
      r1_rdata <= 32'd0;
      err      <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      led_cs   <= 1'b0;
      sw_cs    <= 1'b0;
      io_wdata <= 16'd0;
    end else begin
      state <= state_nxt;

      // Everything below is a single-cycle pulse unless re-asserted.
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      err      <= 1'b0;
      m_en     <= 1'b0;
      m_we     <= 1'b0;
      m_addr   <= 32'd0;
      m_wdata  <= 32'd0;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      led_cs   <= 1'b0;
      sw_cs    <= 1'b0;
      io_wdata <= 16'd0;

      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner <= sel;
            we_q  <= sel_we;
            io_q  <= sel_io;
            unm_q <= sel_io && !sel_led && !sel_sw;
            if (!sel_io) begin
              m_en    <= 1'b1;
              m_we    <= sel_we;
              m_addr  <= sel_addr;
              m_wdata <= sel_we ? sel_wdata : 32'd0;
            end else if (sel_led || sel_sw) begin
              io_rd    <= !sel_we;
              io_wr    <= sel_we;
              led_cs   <= sel_led;
              sw_cs    <= sel_sw;
              io_wdata <= sel_we ? sel_wdata[15:0] : 16'd0;
            end
          end
        end

        ISSUE: begin
          if (!io_q && !we_q) begin
            cnt <= LAT_M1;
          end else begin
            if (owner) r1_ack <= 1'b1;
            else       r0_ack <= 1'b1;
            err <= unm_q;
            // IO read data is sampled combinationally from the device here;
            // an unmapped read returns zero.
            if (io_q && !we_q) begin
              if (owner) r1_rdata <= unm_q ? 32'd0 : {16'd0, io_rdata};
              else       r0_rdata <= unm_q ? 32'd0 : {16'd0, io_rdata};
            end
          end
        end

        WAIT: begin
          if (cnt == 3'd0) begin
            if (owner) begin
              r1_ack   <= 1'b1;
              r1_rdata <= m_rdata;
            end else begin
              r0_ack   <= 1'b1;
              r0_rdata <= m_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end

        ACK: begin
          last <= owner;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Purpose : directed self-checking bench for mem_io_arbiter (MEM_LAT = 1).
// Latency : inputs change and outputs are sampled on the falling edge; cycle n is the n-th falling edge after the request is raised.
// Backpr. : requests are held until their ack, then dropped unless the step says otherwise.
module tb_mem_io_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0;
  logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
  logic        r1_req = 1'b0, r1_we = 1'b0;
  logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
  logic        r0_ack, r1_ack, err;
  logic [31:0] r0_rdata, r1_rdata;
  logic        m_en, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [31:0] m_rdata = 32'd0;
  logic        io_rd, io_wr, led_cs, sw_cs;
  logic [15:0] io_wdata;
  logic [15:0] io_rdata = 16'd0;
  logic        owner, busy;

  logic [31:0] mem_val = 32'hDEADBEEF;

  int tests = 0;
  int fails = 0;

  mem_io_arbiter #(.MEM_LAT(1)) dut (
    .clock(clock), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .err(err),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .io_rd(io_rd), .io_wr(io_wr), .led_cs(led_cs), .sw_cs(sw_cs),
    .io_wdata(io_wdata), .io_rdata(io_rdata),
    .owner(owner), .busy(busy)
  );

  always #5 clock = ~clock;

  // One-cycle-latency memory: data for a read strobed in cycle n is on m_rdata in cycle n+1.
  always @(posedge clock) begin
    if (m_en && !m_we) m_rdata <= mem_val;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  int   ack_n [4];
  logic ack_id[4];
  logic ack_own[4];
  int   na;
  int   bad;

  initial begin
    // ---------------- reset state ----------------
    #2;
    chk("rst_strobes", {m_en, m_we, io_rd, io_wr, led_cs, sw_cs}, 32'd0);
    chk("rst_acks", {r0_ack, r1_ack, err, owner, busy}, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // ---------------- r0 memory read, MEM_LAT = 1 ----------------
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h00000010;
    cyc();                                                  // cycle 1: ISSUE
    chk("rd_c1_m_en", m_en, 1'b1);
    chk("rd_c1_m_we", m_we, 1'b0);
    chk("rd_c1_m_addr", m_addr, 32'h00000010);
    chk("rd_c1_busy_owner", {busy, owner}, 2'b10);
    cyc();                                                  // cycle 2: WAIT
    chk("rd_c2_no_ack", {r0_ack, r1_ack, m_en}, 3'b000);
    cyc();                                                  // cycle 3: ACK
    chk("rd_c3_ack", {r0_ack, r1_ack, err}, 3'b100);
    chk("rd_c3_rdata", r0_rdata, 32'hDEADBEEF);
    r0_req = 1'b0;
    cyc();
    chk("rd_idle_busy", busy, 1'b0);

    // ---------------- r0 memory write keeps rdata ----------------
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'h00000020; r0_wdata = 32'h00000055;
    cyc();
    chk("wr_c1_m", {m_en, m_we}, 2'b11);
    chk("wr_c1_m_wdata", m_wdata, 32'h00000055);
    cyc();
    chk("wr_c2_ack", {r0_ack, r1_ack, err}, 3'b100);
    chk("wr_c2_rdata_kept", r0_rdata, 32'hDEADBEEF);
    chk("wr_c2_m_wdata_zero", m_wdata, 32'd0);
    r0_req = 1'b0;
    cyc();

    // ---------------- r1 LED write ----------------
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 32'hFFFFFC60; r1_wdata = 32'h1234ABCD;
    cyc();
    chk("led_c1_strobes", {io_wr, led_cs, io_rd, sw_cs, m_en}, 5'b11000);
    chk("led_c1_io_wdata", io_wdata, 16'hABCD);
    chk("led_c1_owner", owner, 1'b1);
    cyc();
    chk("led_c2_strobes", {io_wr, led_cs, m_en}, 3'b000);
    chk("led_c2_ack", {r0_ack, r1_ack, err}, 3'b010);
    r1_req = 1'b0;
    cyc();

    // ---------------- r0 switch read ----------------
    io_rdata = 16'h00A5;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'hFFFFFC70;
    cyc();
    chk("sw_c1_strobes", {sw_cs, io_rd, led_cs, io_wr, m_en}, 5'b11000);
    cyc();
    chk("sw_c2_ack", {r0_ack, r1_ack, err, sw_cs, io_rd}, 5'b10000);
    chk("sw_c2_rdata", r0_rdata, 32'h000000A5);
    chk("sw_c2_r1_rdata_kept", r1_rdata, 32'd0);
    r0_req = 1'b0;
    cyc();

    // ---------------- r0 unmapped IO read ----------------
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'hFFFFFC10;
    cyc();
    chk("unm_c1_no_strobes", {m_en, io_rd, io_wr, led_cs, sw_cs}, 5'b00000);
    chk("unm_c1_busy", busy, 1'b1);
    cyc();
    chk("unm_c2_ack_err", {r0_ack, r1_ack, err}, 3'b101);
    chk("unm_c2_rdata", r0_rdata, 32'd0);
    r0_req = 1'b0;
    cyc();

    // ---------------- reset mid memory read ----------------
    mem_val = 32'hCAFEF00D;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'h00000010;
    cyc();
    chk("rstmid_c1_m_en", m_en, 1'b1);
    reset = 1'b0;
    #1;
    chk("rstmid_outputs", {m_en, m_we, io_rd, io_wr, led_cs, sw_cs, r0_ack, r1_ack, err, owner, busy}, 32'd0);
    chk("rstmid_addr", m_addr, 32'd0);
    r0_req = 1'b0;
    cyc();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (r0_ack || r1_ack || busy || m_en) bad++;
    end
    chk("rstmid_after_quiet", bad, 0);

    // ---------------- continuous round-robin writes from reset ----------------
    r0_we = 1'b1; r0_addr = 32'h00000100; r0_wdata = 32'h11111111;
    r1_we = 1'b1; r1_addr = 32'h00000200; r1_wdata = 32'h22222222;
    r0_req = 1'b1; r1_req = 1'b1;
    na = 0;
    bad = 0;
    for (int c = 1; c <= 14; c++) begin
      cyc();
      if (r0_ack && r1_ack) bad++;
      if (r0_ack || r1_ack) begin
        if (na < 4) begin
          ack_n[na]   = c;
          ack_id[na]  = r1_ack;
          ack_own[na] = owner;
        end
        na++;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("rr_ack_count_ge4", (na >= 4) ? 1 : 0, 1);
    chk("rr_no_double_ack", bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr_ack%0d_cycle", i), (i < na) ? ack_n[i] : -1, 2 + 3 * i);
      chk($sformatf("rr_ack%0d_id", i), (i < na) ? {31'd0, ack_id[i]} : 32'hFFFFFFFF, i % 2);
      chk($sformatf("rr_ack%0d_owner", i), (i < na) ? {31'd0, ack_own[i]} : 32'hFFFFFFFF, i % 2);
    end
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_io_arbiter.md
# mem_io_arbiter

Two-requester arbiter and access sequencer in front of the data-memory / IO path. It shares the single data-memory port and the 16-bit IO bus between the CPU data port (requester 0) and the UART program loader / debug port (requester 1). It decodes each latched address into memory or IO space and issues exactly one strobe per transaction to the selected target. It returns read data with a one-cycle acknowledge pulse.

## Interface
- `MEM_LAT`, 1: data-memory read latency in cycles, legal 1..4.
- `IO_BASE`, 32'hFFFFFC00: IO region base; IO when `addr[31:10] == IO_BASE[31:10]`.
- `LED_ADDR`, 32'hFFFFFC60: LED register address (word compare, `addr[31:2]`).
- `SW_ADDR`, 32'hFFFFFC70: switch register address (word compare, `addr[31:2]`).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `r0_req`, `r1_req` in 1: access request; held with its qualifiers until ack.
- `r0_we`, `r1_we` in 1: 1 = write, 0 = read.
- `r0_addr`, `r1_addr` in 32: byte address.
- `r0_wdata`, `r1_wdata` in 32: write data.
- `r0_ack`, `r1_ack` out 1: one-cycle completion pulse.
- `r0_rdata`, `r1_rdata` out 32: read data, valid with ack, held until that requester's next ack.
- `err` out 1: pulses with ack for an unmapped IO address.
- `m_en`, `m_we` out 1: memory enable and write strobe.
- `m_addr` out 32: memory address.
- `m_wdata` out 32: memory write data.
- `m_rdata` in 32: memory read data, valid `MEM_LAT` cycles after `m_en`.
- `io_rd`, `io_wr` out 1: IO read and write strobes.
- `led_cs`, `sw_cs` out 1: chip selects, active high.
- `io_wdata` out 16: IO write data.
- `io_rdata` in 16: IO read data, combinational from the device.
- `owner` out 1: requester currently granted.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE behaviour:
  - Samples `r0_req` and `r1_req` at each edge.
  - Exactly one request: grant it.
  - Both requests: round-robin, grant the requester not granted last.
  - On grant, latch `we`, `addr` and `wdata` from the winner, set `owner`, and go to ISSUE.
  - No request: stay in IDLE.
- ISSUE (one cycle):
  - Memory access: `m_en`=1, `m_we`=`we`, `m_addr`=latched address, `m_wdata`=latched data (when writing).
  - IO access: `io_rd` or `io_wr` per `we`. `led_cs` or `sw_cs` per decode. `io_wdata`=latched `wdata[15:0]`.
  - IO read data is captured at the end of ISSUE as `{16'b0, io_rdata}`.
  - Unmapped IO address: no strobe and no chip select; the access completes with `err`=1 and read data 0.
  - Next state: memory read goes to WAIT; every other access goes to ACK.
- WAIT: counts `MEM_LAT` cycles, captures `m_rdata` at the end of the last one, then goes to ACK.
- ACK (one cycle): pulse the owner's ack (and `err` if flagged), update the owner's read data (reads only), flip the last-grant pointer, then go to IDLE.
- Outputs when not strobing: strobes, chip selects, `m_wdata` and `io_wdata` are driven 0. There are no tri-states.
- Requester dropping `req` mid-transaction: the transaction still completes and still acks.
- A write leaves that requester's read data unchanged.

## Timing
- Reset (asynchronous, reset=0) forces all outputs to 0.
  - State goes to IDLE and the last-grant pointer to 1, so requester 0 wins the first tie.
  - A transaction in flight is aborted: no ack and no further strobes.
- Let E0 be the edge at which IDLE samples a request.
  - ISSUE occupies cycle 1.
  - Memory write, IO access, unmapped access: ack in cycle 2.
  - Memory read: ack in cycle 2+`MEM_LAT`.
- Throughput: IDLE lasts at least one cycle between transactions, so back-to-back accesses take latency+1 cycles each.
- A requester holding `req` after its ack is re-arbitrated in the next IDLE.
- Strobes are single-cycle and registered. `m_addr`/`m_wdata` are stable for the whole ISSUE cycle.

## Test plan
- Reset: assert reset mid-memory-read.
  - All outputs go 0 immediately.
  - After release, no ack appears and `busy`=0.
- r0 reads address 0x00000010 with `MEM_LAT`=1 and memory returning 0xDEADBEEF.
  - `m_en` is high in cycle 1.
  - `r0_ack` pulses in cycle 3 with `r0_rdata`=0xDEADBEEF.
- r0 and r1 request continuously from reset, both writing.
  - Grants alternate 0,1,0,1.
  - Each ack arrives 3 cycles after the previous one.
  - `owner` matches every ack.
- r1 writes 0x1234ABCD to 0xFFFFFC60.
  - `io_wr`=`led_cs`=1 for exactly one cycle with `io_wdata`=0xABCD.
  - `m_en` stays 0.
  - `r1_ack` pulses in cycle 2.
- r0 reads 0xFFFFFC70 with `io_rdata`=0x00A5.
  - `sw_cs`=`io_rd`=1 for one cycle.
  - `r0_rdata`=0x000000A5 with ack in cycle 2.
- r0 reads unmapped 0xFFFFFC10.
  - No strobes.
  - `r0_ack`=`err`=1 in cycle 2 with `r0_rdata`=0.
